// File: rtl/mempool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : mempool_pkg                                                   |
// | Description : Shared MemPool memory parameters and the TCDM bank-adapter    |
// |               types (bank select, row address, response record).           |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package mempool_pkg;

    localparam int unsigned AddrWidth        = 32;
    localparam int unsigned DataWidth        = 32;
    localparam int unsigned BeWidth          = DataWidth / 8;
    localparam int unsigned ByteOffset       = $clog2(BeWidth);
    localparam int unsigned BankingFactor    = 4;
    localparam int unsigned TCDMAddrMemWidth = 12;

    localparam int unsigned NumBanks         = BankingFactor;
    localparam int unsigned BankSelWidth     = $clog2(BankingFactor);
    localparam longint unsigned TCDMRegionBytes =
        longint'(BankingFactor) * (longint'(1) << TCDMAddrMemWidth) * longint'(BeWidth);

    typedef logic [AddrWidth-1:0]        addr_t;
    typedef logic [DataWidth-1:0]        data_t;
    typedef logic [BeWidth-1:0]          be_t;
    typedef logic [TCDMAddrMemWidth-1:0] tcdm_addr_t;
    typedef logic [BankSelWidth-1:0]     bank_sel_t;

    typedef struct packed {
        data_t rdata;
        logic  err;
    } tcdm_resp_t;

endpackage
`default_nettype wire

// File: rtl/tcdm_resp_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tcdm_resp_fifo                                                |
// | Description : Synchronous (non fall-through) FIFO of tcdm_resp_t records.   |
// |               A pop and a push in the same cycle are accepted even when     |
// |               full; the freed slot is reused and the count is unchanged.    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports       : clk, rst      clock, asynchronous active-high reset           |
// |               i_push/i_data write side                                      |
// |               i_pop/o_data  read side, o_data is 0 while empty              |
// |               o_full, o_empty, o_count  occupancy status                    |
// +----------------------------------------------------------------------------+
module tcdm_resp_fifo
    import mempool_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  tcdm_resp_t                     i_data,
    input  logic                           i_pop,
    output tcdm_resp_t                     o_data,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(Depth+1)-1:0]     o_count
);

    localparam int unsigned c_ptr_w = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned c_cnt_w = $clog2(Depth + 1);

    tcdm_resp_t             r_mem [Depth];
    logic [c_ptr_w-1:0]     r_wptr;
    logic [c_ptr_w-1:0]     r_rptr;
    logic [c_cnt_w-1:0]     r_count;

    logic                   w_do_pop;
    logic                   w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_cnt_w'(Depth));
    assign o_count   = r_count;

    assign w_do_pop  = i_pop && !o_empty;
    // When full, a concurrent pop frees the slot the write lands in.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Output held at zero while empty so nothing stale is visible.
    assign o_data    = o_empty ? '0 : r_mem[r_rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= (r_wptr == c_ptr_w'(Depth - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= (r_rptr == c_ptr_w'(Depth - 1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: reads are masked while empty.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tcdm_bank_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tcdm_bank_adapter                                             |
// | Description : Core-side TCDM request stream to NumBanks word-interleaved    |
// |               single-port SRAM banks. One bank access per cycle, in-order   |
// |               responses through a credit-guarded response FIFO so a read    |
// |               result is never lost under response back-pressure.            |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports       : clk_i, rst_i          clock, asynchronous active-high reset   |
// |               req_*                 core request (valid/ready handshake)    |
// |               resp_*                core response (valid/ready handshake)   |
// |               bank_req_o            one-hot bank select, handshake cycle    |
// |               bank_we/addr/wdata/be shared bank command, 0 when idle        |
// |               bank_rdata_i          per-bank read data, 1 cycle latency     |
// |               stat_*_o              only with TCDM_BANK_ADAPTER_STATS_EN    |
// | Option      : `define TCDM_BANK_ADAPTER_STATS_EN adds three saturating      |
// |               32-bit counters (in-range reads, in-range writes, stalls).    |
// +----------------------------------------------------------------------------+
module tcdm_bank_adapter
    import mempool_pkg::*;
#(
    parameter int unsigned NumBanks  = BankingFactor,
    parameter int unsigned RespDepth = 4,
    parameter int unsigned RowWidth  = TCDMAddrMemWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [AddrWidth-1:0]          req_addr_i,
    input  logic                          req_wen_i,
    input  logic [DataWidth-1:0]          req_wdata_i,
    input  logic [BeWidth-1:0]            req_be_i,
    output logic                          resp_valid_o,
    input  logic                          resp_ready_i,
    output logic [DataWidth-1:0]          resp_rdata_o,
    output logic                          resp_err_o,
`ifdef TCDM_BANK_ADAPTER_STATS_EN
    output logic [31:0]                   stat_reads_o,
    output logic [31:0]                   stat_writes_o,
    output logic [31:0]                   stat_stall_o,
`endif
    output logic [NumBanks-1:0]           bank_req_o,
    output logic                          bank_we_o,
    output logic [RowWidth-1:0]           bank_addr_o,
    output logic [DataWidth-1:0]          bank_wdata_o,
    output logic [BeWidth-1:0]            bank_be_o,
    input  logic [NumBanks*DataWidth-1:0] bank_rdata_i
);

    localparam int unsigned c_sel_w = $clog2(NumBanks);
    localparam int unsigned c_cnt_w = $clog2(RespDepth + 1);
    localparam int unsigned c_use_w = c_cnt_w + 1;
    localparam longint unsigned c_region_bytes =
        longint'(NumBanks) * (longint'(1) << RowWidth) * longint'(BeWidth);

    // ------------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------------
    logic [c_sel_w-1:0]  w_bank;
    logic [RowWidth-1:0] w_row;
    logic                w_in_range;
    logic                w_hs;

    assign w_bank     = req_addr_i[ByteOffset +: c_sel_w];
    assign w_row      = req_addr_i[ByteOffset + c_sel_w +: RowWidth];
    assign w_in_range = (64'(req_addr_i) < c_region_bytes);

    // ------------------------------------------------------------------------
    // Credit: a request may only be accepted if a FIFO slot is guaranteed for
    // its response, counting the one still in the SRAM pipeline. Built from
    // registered state only, so resp_ready_i never reaches req_ready_o.
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0]  w_count;
    logic [c_use_w-1:0]  w_credit_used;
    logic                r_inf_valid;
    logic [c_sel_w-1:0]  r_inf_bank;
    logic                r_inf_write;
    logic                r_inf_err;

    assign w_credit_used = {1'b0, w_count} + c_use_w'(r_inf_valid);
    assign req_ready_o   = (w_credit_used < c_use_w'(RespDepth));
    assign w_hs          = req_valid_i && req_ready_o;

    // ------------------------------------------------------------------------
    // Bank command: only driven during an in-range handshake; otherwise the
    // shared bus is held at zero to avoid toggling into the SRAM macros.
    // ------------------------------------------------------------------------
    always_comb begin
        bank_req_o   = '0;
        bank_we_o    = 1'b0;
        bank_addr_o  = '0;
        bank_wdata_o = '0;
        bank_be_o    = '0;
        if (w_hs && w_in_range) begin
            bank_req_o[w_bank] = 1'b1;
            bank_we_o          = req_wen_i;
            bank_addr_o        = w_row;
            bank_wdata_o       = req_wdata_i;
            bank_be_o          = req_be_i;
        end
    end

    // ------------------------------------------------------------------------
    // Inflight stage: remembers which bank answers next cycle
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_inf_valid <= 1'b0;
            r_inf_bank  <= '0;
            r_inf_write <= 1'b0;
            r_inf_err   <= 1'b0;
        end else begin
            r_inf_valid <= w_hs;
            if (w_hs) begin
                r_inf_bank  <= w_bank;
                r_inf_write <= req_wen_i;
                r_inf_err   <= !w_in_range;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response capture
    // ------------------------------------------------------------------------
    logic [DataWidth-1:0] w_bank_data;
    tcdm_resp_t           w_push_data;
    tcdm_resp_t           w_pop_data;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;

    always_comb begin
        w_bank_data = '0;
        for (int b = 0; b < NumBanks; b++) begin
            if (r_inf_bank == c_sel_w'(b)) begin
                w_bank_data = bank_rdata_i[b*DataWidth +: DataWidth];
            end
        end
    end

    assign w_push            = r_inf_valid;
    assign w_push_data.rdata = (!r_inf_write && !r_inf_err) ? w_bank_data : '0;
    assign w_push_data.err   = r_inf_err;

    assign resp_valid_o      = !w_empty;
    assign w_pop             = resp_valid_o && resp_ready_i;
    assign resp_rdata_o      = w_pop_data.rdata;
    assign resp_err_o        = w_pop_data.err;

    tcdm_resp_fifo #(
        .Depth   (RespDepth)
    ) u_resp_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .o_data  (w_pop_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // The credit rule must make an overflowing push impossible.
    assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_full));

    // ------------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------------
`ifdef TCDM_BANK_ADAPTER_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_hs && w_in_range && !req_wen_i && (r_stat_reads != '1)) begin
                r_stat_reads <= r_stat_reads + 1'b1;
            end
            if (w_hs && w_in_range && req_wen_i && (r_stat_writes != '1)) begin
                r_stat_writes <= r_stat_writes + 1'b1;
            end
            if (req_valid_i && !req_ready_o && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 1'b1;
            end
        end
    end

    assign stat_reads_o  = r_stat_reads;
    assign stat_writes_o = r_stat_writes;
    assign stat_stall_o  = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tcdm_bank_adapter                                          |
// | Description : Self-checking bench for tcdm_bank_adapter with a 4-bank SRAM  |
// |               model, a reference memory and a response scoreboard.         |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tcdm_bank_adapter;
    import mempool_pkg::*;

    localparam int unsigned NB = 4;
    localparam int unsigned RW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [31:0]   req_addr = '0;
    logic          req_wen = 1'b0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [NB-1:0] bank_req;
    logic          bank_we;
    logic [RW-1:0] bank_addr;
    logic [31:0]   bank_wdata;
    logic [3:0]    bank_be;
    logic [NB*32-1:0] bank_rdata = '0;
`ifdef TCDM_BANK_ADAPTER_STATS_EN
    logic [31:0]   stat_reads;
    logic [31:0]   stat_writes;
    logic [31:0]   stat_stall;
`endif

    always #5 clk = ~clk;

    tcdm_bank_adapter #(
        .NumBanks     (NB),
        .RespDepth    (4),
        .RowWidth     (RW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_wen_i    (req_wen),
        .req_wdata_i  (req_wdata),
        .req_be_i     (req_be),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
`ifdef TCDM_BANK_ADAPTER_STATS_EN
        .stat_reads_o (stat_reads),
        .stat_writes_o(stat_writes),
        .stat_stall_o (stat_stall),
`endif
        .bank_req_o   (bank_req),
        .bank_we_o    (bank_we),
        .bank_addr_o  (bank_addr),
        .bank_wdata_o (bank_wdata),
        .bank_be_o    (bank_be),
        .bank_rdata_i (bank_rdata)
    );

    // ------------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    // Reference memory keyed by word index, independent of bank layout.
    logic [31:0] ref_mem [int unsigned];

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        int unsigned key;
        key = a >> 2;
        if (ref_mem.exists(key)) return ref_mem[key];
        return init_val({a[31:2], 2'b00});
    endfunction

    task automatic expect_req(input logic [31:0] a, input logic wen,
                              input logic [31:0] wd, input logic [3:0] be);
        exp_t        e;
        logic        inr;
        logic [31:0] w;
        inr     = (a < 32'h0001_0000);
        e.err   = !inr;
        e.rdata = (inr && !wen) ? ref_read(a) : 32'h0;
        if (inr && wen) begin
            w = ref_read(a);
            for (int k = 0; k < 4; k++) if (be[k]) w[k*8 +: 8] = wd[k*8 +: 8];
            ref_mem[a >> 2] = w;
        end
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------------
    // SRAM bank model (1-cycle read latency)
    // ------------------------------------------------------------------------
    logic [31:0] sram [NB][2**RW];

    initial begin
        for (int b = 0; b < NB; b++)
            for (int r = 0; r < 2**RW; r++)
                sram[b][r] = init_val(32'((r << 4) | (b << 2)));
    end

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_req[b]) begin
                if (bank_we) begin
                    for (int k = 0; k < 4; k++)
                        if (bank_be[k]) sram[b][bank_addr][k*8 +: 8] <= bank_wdata[k*8 +: 8];
                end else begin
                    bank_rdata[b*32 +: 32] <= sram[b][bank_addr];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response monitor
    // ------------------------------------------------------------------------
    exp_t mon_e;
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("resp_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
                check("resp_err", 64'(resp_err), 64'(mon_e.err));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called just after a rising edge)
    // ------------------------------------------------------------------------
    task automatic send(input logic [31:0] a, input logic wen, input logic [31:0] wd,
                        input logic [3:0] be, output int waits);
        logic       inr;
        logic [3:0] oh;
        req_valid = 1'b1;
        req_addr  = a;
        req_wen   = wen;
        req_wdata = wd;
        req_be    = be;
        waits     = 0;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(posedge clk);
            @(negedge clk);
        end
        if (!req_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
        end else begin
            inr = (a < 32'h0001_0000);
            oh  = inr ? (4'b0001 << a[3:2]) : 4'b0000;
            check("bank_req", 64'(bank_req), 64'(oh));
            if (inr) begin
                check("bank_addr", 64'(bank_addr), 64'(a[15:4]));
                check("bank_we", 64'(bank_we), 64'(wen));
                if (wen) check("bank_wdata", 64'(bank_wdata), 64'(wd));
            end
            expect_req(a, wen, wd, be);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_addr  = '0;
        req_wen   = 1'b0;
        req_wdata = '0;
        req_be    = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("drain_done", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    int w;
    int acc;

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_bank_req", 64'(bank_req), 64'd0);
        check("rst_resp_rdata", 64'(resp_rdata), 64'd0);
        check("rst_resp_err", 64'(resp_err), 64'd0);
        @(posedge clk); #1;

        // Write with latency check
        send(32'h0000_0014, 1'b1, 32'hDEAD_BEEF, 4'hF, w);
        idle();
        @(negedge clk);
        check("wr_lat1_valid", 64'(resp_valid), 64'd0);
        check("idle_bank_addr", 64'(bank_addr), 64'd0);
        check("idle_bank_req", 64'(bank_req), 64'd0);
        @(negedge clk);
        check("wr_lat2_valid", 64'(resp_valid), 64'd1);
        drain();

        // Read back with latency check
        send(32'h0000_0014, 1'b0, 32'h0, 4'hF, w);
        idle();
        @(negedge clk);
        check("rd_lat1_valid", 64'(resp_valid), 64'd0);
        @(negedge clk);
        check("rd_lat2_valid", 64'(resp_valid), 64'd1);
        check("rd_lat2_data", 64'(resp_rdata), 64'hDEAD_BEEF);
        drain();

        // Back-to-back reads across all banks
        for (int i = 0; i < 4; i++) begin
            send(32'(i * 4), 1'b0, 32'h0, 4'hF, w);
            check("b2b_stall", 64'(w), 64'd0);
        end
        idle();
        drain();

        // Partial byte-enable write then read back
        send(32'h0000_0024, 1'b1, 32'h1234_5678, 4'b0011, w);
        send(32'h0000_0024, 1'b0, 32'h0, 4'hF, w);
        idle();
        drain();

        // Back-pressure: credits stop acceptance at four
        resp_ready = 1'b0;
        acc        = 0;
        req_valid  = 1'b1;
        req_wen    = 1'b0;
        req_be     = 4'hF;
        req_addr   = 32'h0000_0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (req_ready) begin
                expect_req(req_addr, 1'b0, 32'h0, 4'hF);
                acc++;
            end
            @(posedge clk); #1;
            req_addr = 32'h0000_0100 + 32'(acc * 4);
        end
        check("full_accepts", 64'(acc), 64'd4);
        @(negedge clk);
        check("full_ready_low", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        idle();
        resp_ready = 1'b1;
        @(negedge clk);
        check("ready_before_pop", 64'(req_ready), 64'd0);
        @(negedge clk);
        check("ready_after_pop", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        drain();

        // Out-of-range accesses
        send(32'h0001_0000, 1'b0, 32'h0, 4'hF, w);
        send(32'hFFFF_FFF0, 1'b1, 32'hCAFE_F00D, 4'hF, w);
        send(32'h0000_FFFC, 1'b0, 32'h0, 4'hF, w);
        idle();
        drain();

        // Reset with two requests outstanding
        resp_ready = 1'b0;
        send(32'h0000_0000, 1'b0, 32'h0, 4'hF, w);
        send(32'h0000_0004, 1'b0, 32'h0, 4'hF, w);
        idle();
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            check("post_rst_no_resp", 64'(resp_valid), 64'd0);
            @(negedge clk);
        end

        check("sb_empty_end", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
